// File: rtl/apb_cmd_master.sv
// APB3 initiator: accepts one command at a time on a valid/ready channel, runs
// the SETUP/ACCESS transfer with a bounded wait, and returns the result on a response channel.
module apb_cmd_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic                      w_fire;
  logic                      w_timeout;

  logic [APB_ADDR_WIDTH-1:0] r_paddr,  w_paddr_nxt;
  logic [DATA_W-1:0]         r_pwdata, w_pwdata_nxt;
  logic                      r_pwrite, w_pwrite_nxt;
  logic                      r_psel,   w_psel_nxt;
  logic                      r_penable, w_penable_nxt;
  logic                      r_cmd_ready, w_cmd_ready_nxt;
  logic                      r_busy,   w_busy_nxt;
  logic                      r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]         r_rsp_rdata, w_rsp_rdata_nxt;
  logic                      r_rsp_err, w_rsp_err_nxt;
  logic                      r_rsp_timeout, w_rsp_timeout_nxt;

  assign w_fire    = cmd_valid & r_cmd_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Timeout fires on the ACCESS cycle whose missing PREADY would make the count reach the limit
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // State and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_fire) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (PREADY || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; flags are decoded from the next state
  always_comb begin
    w_cnt_nxt         = '0;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_pwrite_nxt      = r_pwrite;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_paddr_nxt  = cmd_addr;
          w_pwdata_nxt = cmd_wdata;
          w_pwrite_nxt = cmd_write;
        end
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
          w_rsp_err_nxt     = PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
        end else if (w_timeout) begin
          w_rsp_rdata_nxt   = '0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: ;
    endcase
    w_psel_nxt      = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_penable_nxt   = (w_state_nxt == S_ACCESS);
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PWRITE      = r_pwrite;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: one instance with the default timeout and
// one with a 4-cycle timeout; expected values are hand-computed constants.
module tb_apb_cmd_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid, cmd_valid4;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_ready;
  logic [31:0] PRDATA;
  logic        PREADY, PREADY4;
  logic        PSLVERR;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, PWRITE, PSEL, PENABLE;
  logic [31:0] rsp_rdata, PWDATA;
  logic [11:0] PADDR;

  logic        t_cmd_ready, t_rsp_valid, t_rsp_err, t_rsp_timeout, t_busy, t_PWRITE, t_PSEL, t_PENABLE;
  logic [31:0] t_rsp_rdata, t_PWDATA;
  logic [11:0] t_PADDR;

  int n_err = 0;
  int n_chk = 0;
  int acc;
  int nsel;
  int nok;

  apb_cmd_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(256)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_cmd_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) u_dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid4), .cmd_ready(t_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(t_rsp_rdata),
    .rsp_err(t_rsp_err), .rsp_timeout(t_rsp_timeout), .busy(t_busy),
    .PADDR(t_PADDR), .PWDATA(t_PWDATA), .PWRITE(t_PWRITE), .PSEL(t_PSEL), .PENABLE(t_PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY4), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Handshake a command on the default instance; returns in the SETUP cycle
  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d);
    int t = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && t < 20) begin step(); t++; end
    chkb("issue_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic issue4(input logic w, input logic [11:0] a, input logic [31:0] d);
    int t = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid4 = 1'b1;
    while (!t_cmd_ready && t < 20) begin step(); t++; end
    chkb("issue4_ready", t_cmd_ready, 1'b1);
    step();
    cmd_valid4 = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc);
    int t = 0;
    while (!rsp_valid && t < maxc) begin step(); t++; end
    chkb("wait_rsp_valid", rsp_valid, 1'b1);
  endtask

  initial begin
    HRESETn = 1'b1; cmd_valid = 1'b0; cmd_valid4 = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1; PRDATA = '0;
    PREADY = 1'b1; PREADY4 = 1'b0; PSLVERR = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    chkb("rst_cmd_ready", cmd_ready, 1'b0);
    chkb("rst_psel", PSEL, 1'b0);
    chkb("rst_penable", PENABLE, 1'b0);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_paddr", 32'(PADDR), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    #19 HRESETn = 1'b1;
    step();
    chkb("idle_cmd_ready", cmd_ready, 1'b1);
    chkb("idle_busy", busy, 1'b0);

    // 1: write, PREADY tied high, exact latency
    issue(1'b1, 12'h004, 32'hDEADBEEF);
    chkb("t1_setup_psel", PSEL, 1'b1);
    chkb("t1_setup_penable", PENABLE, 1'b0);
    chkb("t1_setup_busy", busy, 1'b1);
    chkb("t1_setup_cmd_ready", cmd_ready, 1'b0);
    step();
    chkb("t1_acc_psel", PSEL, 1'b1);
    chkb("t1_acc_penable", PENABLE, 1'b1);
    chk("t1_acc_paddr", 32'(PADDR), 32'h004);
    chk("t1_acc_pwdata", PWDATA, 32'hDEADBEEF);
    chkb("t1_acc_pwrite", PWRITE, 1'b1);
    chkb("t1_acc_rsp_valid", rsp_valid, 1'b0);
    step();
    chkb("t1_rsp_valid", rsp_valid, 1'b1);
    chkb("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0);
    chkb("t1_rsp_timeout", rsp_timeout, 1'b0);
    chkb("t1_rsp_psel", PSEL, 1'b0);
    step();
    chkb("t1_done_rsp_valid", rsp_valid, 1'b0);
    chkb("t1_done_cmd_ready", cmd_ready, 1'b1);

    // 2: read with 5 wait states
    PREADY = 1'b0; PRDATA = 32'h0;
    issue(1'b0, 12'h010, 32'h0);
    acc = 0; nsel = 0;
    for (int i = 0; i < 20 && PSEL; i++) begin
      if (PADDR == 12'h010 && !PWRITE) nsel++;
      if (PENABLE) acc++;
      if (acc == 6) begin PREADY = 1'b1; PRDATA = 32'h12345678; end
      step();
    end
    chk("t2_paddr_stable_cycles", 32'(nsel), 32'd7);
    chk("t2_access_cycles", 32'(acc), 32'd6);
    chkb("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);
    chkb("t2_rsp_err", rsp_err, 1'b0);
    chkb("t2_rsp_timeout", rsp_timeout, 1'b0);
    PREADY = 1'b0;
    step();

    // 3: slave error on read, then a clean write
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hAAAA5555;
    issue(1'b0, 12'h018, 32'h0);
    wait_rsp(10);
    chkb("t3_err", rsp_err, 1'b1);
    chkb("t3_timeout", rsp_timeout, 1'b0);
    chk("t3_rdata", rsp_rdata, 32'hAAAA5555);
    PSLVERR = 1'b0;
    step();
    issue(1'b1, 12'h01C, 32'h0000CAFE);
    wait_rsp(10);
    chkb("t3w_err", rsp_err, 1'b0);
    chkb("t3w_timeout", rsp_timeout, 1'b0);
    chk("t3w_rdata", rsp_rdata, 32'h0);
    step();

    // 5: response back-pressure with a queued command
    rsp_ready = 1'b0; PRDATA = 32'h0BADF00D;
    issue(1'b0, 12'h030, 32'h0);
    wait_rsp(10);
    cmd_write = 1'b1; cmd_addr = 12'h034; cmd_wdata = 32'h00000055; cmd_valid = 1'b1;
    PRDATA = 32'hFFFFFFFF; PSLVERR = 1'b1;
    nok = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid && rsp_rdata == 32'h0BADF00D && !rsp_err && !cmd_ready && !PSEL && busy) nok++;
      step();
    end
    chk("t5_stable_cycles", 32'(nok), 32'd10);
    rsp_ready = 1'b1; PSLVERR = 1'b0;
    step();
    chkb("t5_idle_cmd_ready", cmd_ready, 1'b1);
    chkb("t5_idle_rsp_valid", rsp_valid, 1'b0);
    chkb("t5_idle_busy", busy, 1'b0);
    step();
    cmd_valid = 1'b0;
    chkb("t5_next_psel", PSEL, 1'b1);
    chk("t5_next_paddr", 32'(PADDR), 32'h034);
    chkb("t5_next_pwrite", PWRITE, 1'b1);
    PREADY = 1'b1;
    wait_rsp(10);
    chkb("t5_next_err", rsp_err, 1'b0);
    step();

    // 4: 4-cycle timeout instance, stuck PREADY then PREADY on the last cycle
    PREADY4 = 1'b0; PRDATA = 32'h77777777;
    issue4(1'b0, 12'h040, 32'h0);
    acc = 0;
    for (int i = 0; i < 30 && !t_rsp_valid; i++) begin
      if (t_PSEL && t_PENABLE && t_PADDR == 12'h040 && !t_PWRITE) acc++;
      step();
    end
    chk("t4_access_cycles", 32'(acc), 32'd4);
    chkb("t4_rsp_valid", t_rsp_valid, 1'b1);
    chkb("t4_psel", t_PSEL, 1'b0);
    chkb("t4_busy", t_busy, 1'b1);
    chkb("t4_err", t_rsp_err, 1'b1);
    chkb("t4_timeout", t_rsp_timeout, 1'b1);
    chk("t4_rdata", t_rsp_rdata, 32'h0);
    chk("t4_pwdata", t_PWDATA, 32'h0);
    step();
    issue4(1'b0, 12'h044, 32'h0);
    acc = 0;
    for (int i = 0; i < 30 && !t_rsp_valid; i++) begin
      if (t_PENABLE) begin
        acc++;
        if (acc == 4) PREADY4 = 1'b1;
      end
      step();
    end
    chk("t4b_access_cycles", 32'(acc), 32'd4);
    chkb("t4b_err", t_rsp_err, 1'b0);
    chkb("t4b_timeout", t_rsp_timeout, 1'b0);
    chk("t4b_rdata", t_rsp_rdata, 32'h77777777);
    PREADY4 = 1'b0;
    step();

    // 6: asynchronous reset mid-ACCESS
    PREADY = 1'b0;
    issue(1'b0, 12'h050, 32'h0);
    step();
    chkb("t6_in_access", PENABLE, 1'b1);
    #2 HRESETn = 1'b0;
    #1;
    chkb("t6_rst_psel", PSEL, 1'b0);
    chkb("t6_rst_penable", PENABLE, 1'b0);
    chkb("t6_rst_rsp_valid", rsp_valid, 1'b0);
    chkb("t6_rst_busy", busy, 1'b0);
    @(posedge HCLK);
    #3 HRESETn = 1'b1;
    step();
    chkb("t6_post_cmd_ready", cmd_ready, 1'b1);
    chkb("t6_post_busy", busy, 1'b0);
    chkb("t6_post_rsp_valid", rsp_valid, 1'b0);
    PREADY = 1'b1;
    issue(1'b1, 12'h060, 32'h13579BDF);
    chkb("t6_new_psel", PSEL, 1'b1);
    chkb("t6_new_penable", PENABLE, 1'b0);
    wait_rsp(10);
    chkb("t6_new_err", rsp_err, 1'b0);
    chkb("t6_new_timeout", rsp_timeout, 1'b0);
    chk("t6_new_pwdata", PWDATA, 32'h13579BDF);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
